pulse_stretcher: RTL and testbench
==================================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of cycles lvl is held high per pulse (legal range 1..65535).
REQ-002 SHALL have parameter GAP, default 2, minimum number of low cycles between consecutive pulses (legal range 1..65535).
REQ-003 SHALL have parameter PEND_W, default 3, width of the pending-request counter; maximum pending count is 2^PEND_W-1.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port tick, input, 1, one-cycle request strobe, synchronous to clk; each high cycle is one request.
REQ-007 SHALL have port clr_ovf, input, 1, synchronous clear of overflow.
REQ-008 SHALL have port lvl, output, 1, stretched pulse, driven directly from a flop.
REQ-009 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-010 SHALL have port pending, output, PEND_W, count of accepted requests not yet started.
REQ-011 SHALL have port overflow, output, 1, sticky flag for dropped requests.

Function
REQ-012 SHALL implement FSM states IDLE (lvl=0), HIGH (lvl=1), GAP (lvl=0), plus one phase counter sized to hold max(WIDTH,GAP)-1.
REQ-013 SHALL, in IDLE with tick=1 at edge k, enter HIGH so that lvl=1 from edge k+1; pending stays unchanged.
REQ-014 SHALL remain in HIGH for exactly WIDTH cycles, then enter GAP.
REQ-015 SHALL remain in GAP for exactly GAP cycles.
REQ-016 SHALL, in the last GAP cycle, compute eff = pending + tick; if eff > 0, enter HIGH with pending_next = eff-1; otherwise enter IDLE.
REQ-017 SHALL, in HIGH or in any GAP cycle other than the last, increment pending on tick=1 when pending < max.
REQ-018 SHALL, on tick=1 in HIGH or non-last GAP with pending = max, drop the request, hold pending at max, and set overflow.
REQ-019 SHALL not set overflow on tick in the last GAP cycle with pending = max; eff-1 = max and pending stays max.
REQ-020 SHALL clear overflow on clr_ovf=1 unless an overflow event occurs in the same cycle; set wins.
REQ-021 SHALL drive busy combinationally from the state register only (busy = state != IDLE).
REQ-022 SHALL produce lvl pulses of exactly WIDTH cycles with at least GAP low cycles between them, never glitching or merging pulses; back-to-back requests give a period of WIDTH+GAP.
REQ-023 SHALL take any illegal state encoding to IDLE on the next clock.

Reset
REQ-024 SHALL, while rst=1, force state=IDLE, phase counter=0, lvl=0, busy=0, pending=0, overflow=0, independent of clk.
REQ-025 SHALL, on rst assertion mid-pulse, drop lvl immediately (asynchronously) and discard all pending requests.
REQ-026 SHALL ignore tick in the cycle in which rst deasserts only if tick is sampled while rst=1; the first edge with rst=0 samples tick normally.

Verification
REQ-027 SHALL cover: defaults, single tick at cycle 0 -> lvl=1 in cycles 1-4, busy=1 in cycles 1-6, IDLE and busy=0 from cycle 7, pending=0 throughout.
REQ-028 SHALL cover: defaults, ticks at cycles 0,1,2 -> pending=2 after cycle 2; lvl high in cycles 1-4, 7-10 and 13-16; busy=0 from cycle 19.
REQ-029 SHALL cover: defaults, ticks at cycles 0 and 6 (last GAP cycle) -> second pulse lvl=1 in cycles 7-10, with no IDLE cycle between the pulses and pending=0.
REQ-030 SHALL cover: WIDTH=16, PEND_W=3, tick held high in cycles 0-9 -> pending=7 after cycle 7, overflow=1 after cycle 8, pending stays 7; clr_ovf at cycle 12 -> overflow=0 at cycle 13.
REQ-031 SHALL cover: overflow event and clr_ovf=1 in the same cycle -> overflow=1 afterwards.
REQ-032 SHALL cover: rst pulsed during cycle 2 of a pulse with pending=3 -> lvl=0, busy=0, pending=0 immediately; the next tick after release produces a full WIDTH-cycle pulse.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle tick requests into WIDTH-cycle lvl pulses separated by at least GAP low cycles.
// Requests that arrive during a pulse are queued in a saturating pending counter with a sticky overflow flag.
module pulse_stretcher #(
    parameter int WIDTH  = 4,
    parameter int GAP    = 2,
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              clr_ovf,
    output logic              lvl,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int PHASE_MAX = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int CNT_W     = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

    localparam logic [CNT_W-1:0]  C_HIGH_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  C_GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] C_PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] C_PEND_ONE  = PEND_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_lvl;
    logic [PEND_W-1:0]  r_pend;
    logic               r_ovf;

    logic w_gap_last;
    logic w_queue_slot;
    logic w_pend_inc;
    logic w_ovf_set;

    assign w_gap_last   = (r_state == ST_GAP) && (r_cnt == C_GAP_LAST);
    // Ticks during HIGH or a non-final GAP cycle are queued; the final GAP cycle consumes tick directly.
    assign w_queue_slot = tick && ((r_state == ST_HIGH) || ((r_state == ST_GAP) && !w_gap_last));
    assign w_pend_inc   = w_queue_slot && (r_pend != C_PEND_MAX);
    assign w_ovf_set    = w_queue_slot && (r_pend == C_PEND_MAX);

    // NOTE: async reset lives in the sensitivity list so lvl drops without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
            r_pend  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (tick) begin
                        r_state <= ST_HIGH;
                        r_lvl   <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_HIGH: begin
                    if (w_pend_inc) r_pend <= r_pend + C_PEND_ONE;
                    if (r_cnt == C_HIGH_LAST) begin
                        r_state <= ST_GAP;
                        r_lvl   <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (w_gap_last) begin
                        r_cnt <= '0;
                        // eff = pending + tick; a live tick replaces the queued entry we would consume.
                        if (tick || (r_pend != '0)) begin
                            r_state <= ST_HIGH;
                            r_lvl   <= 1'b1;
                            if (!tick) r_pend <= r_pend - C_PEND_ONE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        if (w_pend_inc) r_pend <= r_pend + C_PEND_ONE;
                        r_cnt <= r_cnt + C_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_lvl   <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign lvl      = r_lvl;
    assign busy     = (r_state != ST_IDLE);
    assign pending  = r_pend;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default instance plus a WIDTH=16 instance for pending saturation.
// Cycle c is the clock period after the c-th sampling edge; inputs and outputs are handled 1 time unit past each edge.
module tb_pulse_stretcher;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_a, clr_a, lvl_a, busy_a, ovf_a;
    logic [2:0] pend_a;
    logic       tick_b, clr_b, lvl_b, busy_b, ovf_b;
    logic [2:0] pend_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pulse_stretcher dut_a (
        .clk(clk), .rst(rst), .tick(tick_a), .clr_ovf(clr_a),
        .lvl(lvl_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a)
    );

    pulse_stretcher #(.WIDTH(16), .GAP(2), .PEND_W(3)) dut_b (
        .clk(clk), .rst(rst), .tick(tick_b), .clr_ovf(clr_b),
        .lvl(lvl_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b)
    );

    task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick_a = 1'b0; clr_a = 1'b0;
        tick_b = 1'b0; clr_b = 1'b0;

        // Reset state, observed before any clock edge.
        #2;
        check("rst_lvl",  0, lvl_a,  0);
        check("rst_busy", 0, busy_a, 0);
        check("rst_pend", 0, pend_a, 0);
        check("rst_ovf",  0, ovf_a,  0);
        do_reset();

        // Single tick at cycle 0.
        for (int c = 0; c <= 8; c++) begin
            check("t1_lvl",  c, lvl_a,  (c >= 1 && c <= 4));
            check("t1_busy", c, busy_a, (c >= 1 && c <= 6));
            check("t1_pend", c, pend_a, 0);
            tick_a = (c == 0);
            step();
        end
        tick_a = 1'b0;

        // Ticks at cycles 0,1,2: three pulses at period WIDTH+GAP.
        for (int c = 0; c <= 20; c++) begin
            int ep;
            ep = (c <= 1) ? 0 : (c == 2) ? 1 : (c <= 6) ? 2 : (c <= 12) ? 1 : 0;
            check("t2_lvl",  c, lvl_a,  ((c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16)));
            check("t2_busy", c, busy_a, (c >= 1 && c <= 18));
            check("t2_pend", c, pend_a, ep);
            tick_a = (c <= 2);
            step();
        end
        tick_a = 1'b0;

        // Ticks at 0 and 6 (last GAP cycle): second pulse follows with no IDLE cycle.
        for (int c = 0; c <= 13; c++) begin
            check("t3_lvl",  c, lvl_a,  ((c >= 1 && c <= 4) || (c >= 7 && c <= 10)));
            check("t3_busy", c, busy_a, (c >= 1 && c <= 12));
            check("t3_pend", c, pend_a, 0);
            tick_a = (c == 0 || c == 6);
            step();
        end
        tick_a = 1'b0;

        // WIDTH=16: saturate pending, overflow, clear, then overflow and clear together.
        for (int c = 0; c <= 16; c++) begin
            int ep;
            ep = (c <= 1) ? 0 : ((c - 1 > 7) ? 7 : c - 1);
            check("t4_lvl",  c, lvl_b,  (c >= 1));
            check("t4_pend", c, pend_b, ep);
            check("t4_ovf",  c, ovf_b,  ((c >= 9 && c <= 12) || c >= 15));
            tick_b = (c <= 9) || (c == 14);
            clr_b  = (c == 12) || (c == 14);
            step();
        end
        tick_b = 1'b0;
        clr_b  = 1'b0;

        do_reset();
        check("t4_rst_pend", 0, pend_b, 0);
        check("t4_rst_ovf",  0, ovf_b,  0);

        // Build pending=3 and land in cycle 2 of the second pulse, then reset asynchronously.
        for (int c = 0; c <= 8; c++) begin
            int ep;
            ep = (c <= 1) ? 0 : (c == 2) ? 1 : (c == 3) ? 2 : (c <= 5) ? 3 : (c == 6) ? 4 : 3;
            check("t5_lvl",  c, lvl_a,  ((c >= 1 && c <= 4) || c >= 7));
            check("t5_pend", c, pend_a, ep);
            if (c < 8) begin
                tick_a = (c <= 3) || (c == 5);
                step();
            end
        end
        tick_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_lvl",  8, lvl_a,  0);
        check("t5_async_busy", 8, busy_a, 0);
        check("t5_async_pend", 8, pend_a, 0);
        step();
        step();
        rst = 1'b0;

        // First edge after release samples tick normally and yields a full pulse.
        for (int c = 0; c <= 7; c++) begin
            check("t6_lvl",  c, lvl_a,  (c >= 1 && c <= 4));
            check("t6_busy", c, busy_a, (c >= 1 && c <= 6));
            check("t6_pend", c, pend_a, 0);
            tick_a = (c == 0);
            step();
        end
        tick_a = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
